mmio_uart_ctrl: RTL and testbench

Memory-mapped I/O controller between the CPU's MEM stage and the on-chip UART. It replaces the single-byte UART handshake path with parametrised TX and RX FIFOs and exposes status, data and cycle/instruction counters at fixed offsets. Read data is registered, so it returns one cycle after the request, aligned with synchronous DMEM/BIOS reads at the writeback mux.

---
 rtl/mmio_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mmio_uart_ctrl.sv | 154 +++++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared offsets, status bit positions and access decode for the MMIO UART controller.
package mmio_pkg;

  localparam logic [7:0] OFS_STATUS  = 8'h00;
  localparam logic [7:0] OFS_RX      = 8'h04;
  localparam logic [7:0] OFS_TX      = 8'h08;
  localparam logic [7:0] OFS_CYC     = 8'h10;
  localparam logic [7:0] OFS_INST    = 8'h14;
  localparam logic [7:0] OFS_CNT_CLR = 8'h18;

  localparam int unsigned ST_TX_RDY = 0;
  localparam int unsigned ST_RX_VLD = 1;
  localparam int unsigned ST_OVR    = 2;

  typedef enum logic [2:0] {
    AccNone,
    AccStatus,
    AccRx,
    AccTx,
    AccCyc,
    AccInst,
    AccCntClr
  } acc_e;

  function automatic acc_e decode_ofs(input logic [7:0] ofs);
    case (ofs)
      OFS_STATUS:  return AccStatus;
      OFS_RX:      return AccRx;
      OFS_TX:      return AccTx;
      OFS_CYC:     return AccCyc;
      OFS_INST:    return AccInst;
      OFS_CNT_CLR: return AccCntClr;
      default:     return AccNone;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Empty reads as zero so downstream never sees stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // No bypass: a pop on empty does nothing even if a push lands this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO bridge from the MEM stage to the UART with TX/RX FIFOs and cycle/instret counters.
// Define RISCV_MMIO_OVERRUN_EN to build the sticky RX overrun flag and its clear.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rd_data,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic           sel, rd, wr;
  acc_e           acc;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_rdata;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           ovr;
  logic [31:0]    status, rd_mux;
  logic [31:0]    rd_q, rd_d;
  logic           cnt_clr;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, inst_q, inst_d;
  logic           unused_bits;

  assign sel = req_valid && (req_addr[31:28] == BASE_NIBBLE);
  assign rd  = sel && !req_we;
  assign wr  = sel && req_we;
  assign acc = decode_ofs(req_addr[7:0]);

  assign tx_push       = wr && (acc == AccTx);
  assign uart_tx_valid = !tx_empty;
  assign tx_pop        = uart_tx_valid && uart_tx_ready;
  assign rx_pop        = rd && (acc == AccRx) && !rx_empty;
  assign uart_rx_ready = 1'b1;
  assign cnt_clr       = wr && (acc == AccCntClr);

  assign unused_bits = ^{req_wdata[31:8], req_addr[27:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (req_wdata[7:0]),
    .rdata (uart_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_valid),
    .pop   (rx_pop),
    .wdata (uart_rx_data),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

`ifdef RISCV_MMIO_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Set is applied last so a same-cycle drop beats a software clear.
  always_comb begin
    ovr_d = ovr_q;
    if (wr && (acc == AccStatus) && req_wdata[ST_OVR]) ovr_d = 1'b0;
    if (uart_rx_valid && rx_full && !rx_pop)             ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[ST_TX_RDY] = !tx_full;
    status[ST_RX_VLD] = !rx_empty;
    status[ST_OVR]    = ovr;
    status[15:8]      = 8'(rx_count);
    status[23:16]     = 8'(tx_count);
  end

  always_comb begin
    rd_mux = '0;
    case (acc)
      AccStatus: rd_mux = status;
      AccRx:     rd_mux = {24'b0, rx_rdata};
      AccCyc:    rd_mux = 32'(cyc_q);
      AccInst:   rd_mux = 32'(inst_q);
      default:   rd_mux = '0;
    endcase
  end

  // Read data holds between selected loads.
  assign rd_d    = rd ? rd_mux : rd_q;
  assign rd_data = rd_q;

  always_comb begin
    cyc_d  = cyc_q + CntOne;
    inst_d = inst_retire ? inst_q + CntOne : inst_q;
    if (cnt_clr) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      rd_q   <= rd_d;
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl with hand-computed expected values.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rd_data;
  logic        inst_retire;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;

  int total = 0;
  int bad   = 0;

`ifdef RISCV_MMIO_OVERRUN_EN
  localparam logic [31:0] OvrBit = 32'h4;
`else
  localparam logic [31:0] OvrBit = 32'h0;
`endif

  localparam logic [31:0] AStatus = 32'h8000_0000;
  localparam logic [31:0] ARx     = 32'h8000_0004;
  localparam logic [31:0] ATx     = 32'h8000_0008;
  localparam logic [31:0] ACyc    = 32'h8000_0010;
  localparam logic [31:0] AInst   = 32'h8000_0014;
  localparam logic [31:0] AClr    = 32'h8000_0018;

  mmio_uart_ctrl #(
    .TX_DEPTH    (8),
    .RX_DEPTH    (8),
    .CNT_WIDTH   (32),
    .BASE_NIBBLE (4'h8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rd_data       (rd_data),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    data = rd_data;
  endtask

  logic [31:0] r;
  logic [7:0]  exp_rx [8];

  initial begin
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    inst_retire = 0; uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
    do_reset();

    check("rst_rd_data", rd_data, 32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("rx_ready_tied", {31'b0, uart_rx_ready}, 32'h1);

    load(32'h8000_000C, r); check("unmapped_read", r, 32'h0);
    load(AStatus, r);       check("status_idle", r, 32'h1);
    load(32'h9000_0000, r); check("other_nibble_holds", r, 32'h1);

    // TX ordering: one byte per cycle starting the cycle after the first store.
    uart_tx_ready = 1'b1;
    req_valid = 1; req_we = 1; req_addr = ATx; req_wdata = 32'h41;
    check("tx_not_yet_valid", {31'b0, uart_tx_valid}, 32'h0);
    tick();
    req_wdata = 32'h42;
    check("tx_b0", {23'b0, uart_tx_valid, uart_tx_data}, 32'h141);
    tick();
    req_wdata = 32'h43;
    check("tx_b1", {23'b0, uart_tx_valid, uart_tx_data}, 32'h142);
    tick();
    req_valid = 0; req_we = 0;
    check("tx_b2", {23'b0, uart_tx_valid, uart_tx_data}, 32'h143);
    tick();
    check("tx_drained", {31'b0, uart_tx_valid}, 32'h0);

    // TX overflow: ninth store dropped.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(ATx, 32'h10 + i);
    load(AStatus, r); check("tx_full_status", r, 32'h0008_0000);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_full_drain", {23'b0, uart_tx_valid, uart_tx_data}, 32'h110 + i);
      tick();
    end
    check("tx_ninth_dropped", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // RX overflow.
    for (int i = 1; i <= 9; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(i);
      tick();
    end
    uart_rx_valid = 1'b0;
    load(AStatus, r); check("rx_full_status", r, 32'h0000_0803 | OvrBit);
    for (int i = 1; i <= 8; i++) begin
      load(ARx, r); check("rx_pop_order", r, i);
    end
    load(ARx, r);     check("rx_empty_read", r, 32'h0);
    load(AStatus, r); check("rx_drained_status", r, 32'h1 | OvrBit);
    store(AStatus, 32'h4);
    load(AStatus, r); check("ovr_cleared", r, 32'h1);

    // Empty pop with same-cycle push: no bypass.
    req_valid = 1; req_we = 0; req_addr = ARx;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h55;
    tick();
    req_valid = 0; uart_rx_valid = 1'b0;
    check("rx_no_bypass", rd_data, 32'h0);
    load(ARx, r); check("rx_after_no_bypass", r, 32'h55);

    // Full RX with same-cycle pop and push.
    for (int i = 0; i < 8; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'h20 + 8'(i);
      tick();
    end
    req_valid = 1; req_we = 0; req_addr = ARx;
    uart_rx_data = 8'h30;
    tick();
    req_valid = 0; uart_rx_valid = 1'b0;
    check("rx_full_poppush_data", rd_data, 32'h20);
    load(AStatus, r); check("rx_full_poppush_status", r, 32'h0000_0803);
    for (int i = 0; i < 7; i++) exp_rx[i] = 8'h21 + 8'(i);
    exp_rx[7] = 8'h30;
    for (int i = 0; i < 8; i++) begin
      load(ARx, r); check("rx_full_poppush_order", r, {24'b0, exp_rx[i]});
    end

    // Reset with TX contents pending discards them.
    store(ATx, 32'h77);
    do_reset();
    check("rst_mid_tx_valid", {31'b0, uart_tx_valid}, 32'h0);

    // Counters: 100 cycles, retire on every other one.
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
    end
    inst_retire = 1'b0;
    load(ACyc, r);  check("cyc_100", r, 32'd100);
    load(AInst, r); check("inst_50", r, 32'd50);
    store(AClr, 32'hDEAD_BEEF);
    tick();
    load(ACyc, r);  check("cyc_after_clr", r, 32'd1);
    load(AInst, r); check("inst_after_clr", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
